fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h4000_0000, byte address of the first instruction fetched after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port stall  input  1  hold current fetch output (downstream not accepting).
REQ-005 SHALL have port redirect_valid  input  1  branch/jump/trap redirect request.
REQ-006 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-007 SHALL have port imem_dout  input  32  instruction memory read data, 1-cycle synchronous read latency.
REQ-008 SHALL have port imem_addr  output  32  instruction memory byte read address (combinational).
REQ-009 SHALL have port if_pc  output  32  PC of the instruction presented on if_inst.
REQ-010 SHALL have port if_inst  output  32  fetched instruction.
REQ-011 SHALL have port if_valid  output  1  if_pc/if_inst hold a live instruction.

Function
REQ-012 SHALL hold internal registers fetch_pc (32), fetch_valid (1), hold_inst (32), hold_valid (1).
REQ-013 SHALL drive imem_addr by priority: rst -> RESET_PC; redirect_valid -> {redirect_pc[31:2],2'b00}; !fetch_valid -> fetch_pc; stall -> fetch_pc; else fetch_pc + 4.
REQ-014 SHALL compute fetch_pc + 4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-015 SHALL, on a non-reset edge with redirect_valid=1, load fetch_pc <= {redirect_pc[31:2],2'b00}, fetch_valid <= 1, hold_valid <= 0, regardless of stall.
REQ-016 SHALL, on a non-reset edge with redirect_valid=0 and fetch_valid=0, set fetch_valid <= 1 and keep fetch_pc.
REQ-017 SHALL, on a non-reset edge with redirect_valid=0, fetch_valid=1, stall=0, load fetch_pc <= fetch_pc + 4, hold_valid <= 0.
REQ-018 SHALL, on a non-reset edge with redirect_valid=0, fetch_valid=1, stall=1, keep fetch_pc and fetch_valid; if hold_valid=0 capture hold_inst <= imem_dout and set hold_valid <= 1; if hold_valid=1 keep hold_inst.
REQ-019 SHALL drive if_pc = fetch_pc.
REQ-020 SHALL drive if_inst = hold_valid ? hold_inst : imem_dout.
REQ-021 SHALL drive if_valid = fetch_valid & ~redirect_valid (instruction killed combinationally in the redirect cycle).
REQ-022 SHALL keep if_inst constant over any number of consecutive stall cycles, even if imem contents at fetch_pc change during the stall.
REQ-023 SHALL deliver, in steady state without stall/redirect, one instruction per cycle with if_pc increasing by 4 each cycle.
REQ-024 SHALL present the redirect target instruction on if_inst/if_valid in the cycle immediately after the redirect cycle (1-cycle redirect penalty).

Reset
REQ-025 SHALL, on an edge with rst=1, set fetch_pc <= RESET_PC, fetch_valid <= 0, hold_valid <= 0, hold_inst <= 0, overriding stall and redirect_valid.
REQ-026 SHALL, after reset, output if_valid=0, if_pc=RESET_PC, if_inst=imem_dout in the first cycle with rst=0.
REQ-027 SHALL present if_valid=1, if_pc=RESET_PC in the second cycle after rst deasserts (stall=0, no redirect).
REQ-028 SHALL abort any stall hold or pending redirect when rst asserts mid-operation, with identical post-reset behaviour to REQ-025..027.

Verification
REQ-029 SHALL verify reset/startup: rst 2 cycles then stall=0, imem[pc]=pc^32'hA5A5_0000 -> if_valid 0 for 1 cycle, then if_pc 32'h4000_0000, 32'h4000_0004, 32'h4000_0008 with matching if_inst.
REQ-030 SHALL verify stall: stall=1 for 3 cycles while if_pc=32'h4000_0008, overwriting imem word at that address mid-stall -> if_pc, if_inst unchanged all 3 cycles; next cycle if_pc=32'h4000_000C.
REQ-031 SHALL verify redirect: redirect_valid=1, redirect_pc=32'h1000_0102 -> if_valid=0 that cycle; next cycle if_pc=32'h1000_0100, if_valid=1.
REQ-032 SHALL verify redirect during stall: stall=1 and redirect_valid=1 with redirect_pc=32'h2000_0000 -> next cycle if_pc=32'h2000_0000, stall hold discarded.
REQ-033 SHALL verify wrap: redirect to 32'hFFFF_FFFC, stall=0 -> next if_pc values 32'hFFFF_FFFC then 32'h0000_0000.
REQ-034 SHALL verify reset mid-stall: stall=1 with hold_valid set, assert rst 1 cycle -> if_valid=0, if_pc=32'h4000_0000, then REQ-027 sequence.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage for a simple in-order pipeline. It keeps the PC of
// the instruction currently presented downstream, drives the synchronous
// instruction memory read address one instruction ahead, and holds the
// fetched word stable while the downstream stage stalls. A redirect (branch,
// jump, trap) kills the presented instruction combinationally and refetches
// from the target with a single bubble cycle.
//
// Parameters
//   RESET_PC        byte address of the first instruction fetched after reset
//
// Ports
//   clk             sole clock, all state updates on the rising edge
//   rst             synchronous, active-high reset
//   stall           downstream not accepting; hold the current output
//   redirect_valid  redirect request (kills the current instruction)
//   redirect_pc     redirect target byte address (low two bits ignored)
//   imem_dout       instruction memory read data, 1-cycle read latency
//   imem_addr       instruction memory byte read address (combinational)
//   if_pc           PC of the instruction presented on if_inst
//   if_inst         fetched instruction
//   if_valid        if_pc/if_inst hold a live instruction
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] imem_dout,
  output logic [31:0] imem_addr,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  // fetch_pc is the PC whose instruction is (or will next be) on imem_dout.
  // fetch_valid is low only in the bubble cycle right after reset, when the
  // memory has not yet returned the word at fetch_pc.
  logic [31:0] fetch_pc;
  logic        fetch_valid;

  // Skid copy of the instruction taken on the first stalled edge. The memory
  // keeps being read at fetch_pc during a stall, but its contents may change,
  // so the output must come from this copy until the stall releases.
  logic [31:0] hold_inst;
  logic        hold_valid;

  logic [31:0] redirect_target;
  logic [31:0] pc_next_seq;

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  // Plain 32-bit add: 32'hFFFF_FFFC + 4 wraps to zero by truncation.
  assign pc_next_seq     = fetch_pc + 32'd4;

  // The read address always names the word that must appear on imem_dout in
  // the following cycle, so it mirrors the priority of the state update.
  always_comb begin
    // NOTE: a default assignment first means every path assigns imem_addr,
    // so no latch can be inferred.
    imem_addr = pc_next_seq;
    if (rst) begin
      imem_addr = RESET_PC;
    end else if (redirect_valid) begin
      imem_addr = redirect_target;
    end else if (!fetch_valid) begin
      imem_addr = fetch_pc;
    end else if (stall) begin
      imem_addr = fetch_pc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      fetch_valid <= 1'b0;
      hold_valid  <= 1'b0;
      // NOTE: hold_inst is cleared on reset so the skid register never holds
      // an unknown value, even though hold_valid gates its use.
      hold_inst   <= 32'h0000_0000;
    end else if (redirect_valid) begin
      // Redirect wins over stall: the held instruction is on the wrong path.
      fetch_pc    <= redirect_target;
      fetch_valid <= 1'b1;
      hold_valid  <= 1'b0;
    end else if (!fetch_valid) begin
      // Bubble after reset: the word at fetch_pc arrives on this edge.
      fetch_valid <= 1'b1;
    end else if (!stall) begin
      fetch_pc    <= pc_next_seq;
      hold_valid  <= 1'b0;
    end else if (!hold_valid) begin
      // First stalled edge: capture the word before the memory can change it.
      hold_inst   <= imem_dout;
      hold_valid  <= 1'b1;
    end
  end

  assign if_pc    = fetch_pc;
  assign if_inst  = hold_valid ? hold_inst : imem_dout;
  // The instruction in the redirect cycle is on the wrong path.
  assign if_valid = fetch_valid & ~redirect_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed testbench for fetch_stage. A behavioural instruction memory with a
// 1-cycle registered read returns addr ^ 32'hA5A5_0000 for every word, except
// for one word that can be overwritten to model memory changing under a stall.
// Inputs are driven 1 time unit after each rising edge and outputs are checked
// 1 time unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_dout;
  logic [31:0] imem_addr;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int checks = 0;
  int errors = 0;

  // Single overridable word in the memory model.
  logic        ovr_en   = 1'b0;
  logic [31:0] ovr_addr = 32'h0;
  logic [31:0] ovr_data = 32'h0;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_dout      (imem_dout),
    .imem_addr      (imem_addr),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_valid       (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] addr);
    return addr ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (ovr_en && addr == ovr_addr) return ovr_data;
    return pat(addr);
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) imem_dout <= mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving this cycle's inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // ---------------- reset / startup ----------------
    step();
    step();
    rst = 1'b0;
    settle();
    check("rst_c1_valid", {31'b0, if_valid}, 32'd0);
    check("rst_c1_pc",    if_pc,     RESET_PC);
    check("rst_c1_inst",  if_inst,   pat(RESET_PC));
    check("rst_c1_addr",  imem_addr, RESET_PC);

    step(); settle();
    check("rst_c2_valid", {31'b0, if_valid}, 32'd1);
    check("rst_c2_pc",    if_pc,     32'h4000_0000);
    check("rst_c2_inst",  if_inst,   pat(32'h4000_0000));
    check("rst_c2_addr",  imem_addr, 32'h4000_0004);

    step(); settle();
    check("seq_pc4",   if_pc,   32'h4000_0004);
    check("seq_inst4", if_inst, pat(32'h4000_0004));

    // ---------------- stall with memory overwrite ----------------
    step();
    stall = 1'b1;
    settle();
    check("stall1_pc",   if_pc,     32'h4000_0008);
    check("stall1_inst", if_inst,   pat(32'h4000_0008));
    check("stall1_addr", imem_addr, 32'h4000_0008);

    step();
    ovr_en   = 1'b1;
    ovr_addr = 32'h4000_0008;
    ovr_data = 32'hDEAD_BEEF;
    settle();
    check("stall2_pc",   if_pc,   32'h4000_0008);
    check("stall2_inst", if_inst, pat(32'h4000_0008));

    // The memory now returns the overwritten word; output must not follow it.
    step(); settle();
    check("stall3_pc",   if_pc,   32'h4000_0008);
    check("stall3_inst", if_inst, pat(32'h4000_0008));
    check("stall3_dout", imem_dout, 32'hDEAD_BEEF);

    // Stall releases: the held instruction is accepted this cycle.
    step();
    stall = 1'b0;
    settle();
    check("release_pc",    if_pc,   32'h4000_0008);
    check("release_inst",  if_inst, pat(32'h4000_0008));
    check("release_valid", {31'b0, if_valid}, 32'd1);

    step(); settle();
    check("post_stall_pc",   if_pc,   32'h4000_000C);
    check("post_stall_inst", if_inst, pat(32'h4000_000C));

    // ---------------- redirect (misaligned target) ----------------
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1000_0102;
    settle();
    check("redir_kill_valid", {31'b0, if_valid}, 32'd0);
    check("redir_addr",       imem_addr, 32'h1000_0100);

    step();
    redirect_valid = 1'b0;
    settle();
    check("redir_pc",    if_pc,   32'h1000_0100);
    check("redir_valid", {31'b0, if_valid}, 32'd1);
    check("redir_inst",  if_inst, pat(32'h1000_0100));

    step(); settle();
    check("redir_next_pc", if_pc, 32'h1000_0104);

    // ---------------- redirect during stall ----------------
    stall = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2000_0000;
    settle();
    check("rds_hold_inst",  if_inst, pat(32'h1000_0104));
    check("rds_kill_valid", {31'b0, if_valid}, 32'd0);

    step();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    settle();
    check("rds_pc",    if_pc,   32'h2000_0000);
    check("rds_valid", {31'b0, if_valid}, 32'd1);
    check("rds_inst",  if_inst, pat(32'h2000_0000));

    step(); settle();
    check("rds_next_pc", if_pc, 32'h2000_0004);

    // ---------------- PC wrap ----------------
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    settle();
    check("wrap_pc_top",   if_pc,     32'hFFFF_FFFC);
    check("wrap_inst_top", if_inst,   pat(32'hFFFF_FFFC));
    check("wrap_addr",     imem_addr, 32'h0000_0000);

    step(); settle();
    check("wrap_pc_zero",   if_pc,   32'h0000_0000);
    check("wrap_inst_zero", if_inst, 32'hA5A5_0000);

    // ---------------- reset in the middle of a stall ----------------
    stall = 1'b1;
    step(); settle();
    check("mid_stall_inst", if_inst, 32'hA5A5_0000);

    // Reset overrides both the stall and a simultaneous redirect request.
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000_0000;
    settle();
    check("mid_rst_addr", imem_addr, RESET_PC);

    step();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    stall          = 1'b0;
    settle();
    check("mrst_c1_valid", {31'b0, if_valid}, 32'd0);
    check("mrst_c1_pc",    if_pc,   RESET_PC);
    check("mrst_c1_inst",  if_inst, pat(RESET_PC));

    step(); settle();
    check("mrst_c2_valid", {31'b0, if_valid}, 32'd1);
    check("mrst_c2_pc",    if_pc,   32'h4000_0000);
    check("mrst_c2_inst",  if_inst, pat(32'h4000_0000));

    step(); settle();
    check("mrst_c3_pc",   if_pc,   32'h4000_0004);
    check("mrst_c3_inst", if_inst, pat(32'h4000_0004));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
